// File: rtl/bus_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bus_pkg                                                               |
// | Shared constants and sizing helpers for the assert-mux bus family.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package bus_pkg;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_ONE   = 2'd1,
        SEL_MULTI = 2'd2
    } sel_kind_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // A single-source bus still needs a one-bit owner field.
    function automatic int owner_w(input int nsrc);
        return (clog2(nsrc) < 1) ? 1 : clog2(nsrc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_assert_mux_n_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bus_assert_mux_n_if                                                   |
// | Source/assert inputs and bus/contention outputs of one bus mux.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface bus_assert_mux_n_if
    import bus_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NSRC  = 8
);
    localparam int OWNER_W = owner_w(NSRC);

    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       assert_n;
    logic                  clr_err;
    logic [WIDTH-1:0]      bus;
    logic                  bus_valid;
    logic [OWNER_W-1:0]    owner;
    logic                  contention;
    logic                  contention_sticky;
    logic [CNT_W-1:0]      contention_count;

    modport master (
        output src_data, assert_n, clr_err,
        input  bus, bus_valid, owner, contention, contention_sticky, contention_count
    );

    modport slave (
        input  src_data, assert_n, clr_err,
        output bus, bus_valid, owner, contention, contention_sticky, contention_count
    );

endinterface
`default_nettype wire

// File: rtl/bus_assert_prio_enc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bus_assert_prio_enc                                                   |
// | Lowest-index priority encoder with any / multiple-request flags.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module bus_assert_prio_enc
    import bus_pkg::*;
#(
    parameter  int NSRC  = 8,
    localparam int IDX_W = owner_w(NSRC)
) (
    input  logic [NSRC-1:0]  req,
    output logic             any,
    output logic             multi,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        any   = |req;
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi = (req & (req - NSRC'(1))) != '0;
        idx   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = i[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_assert_mux_n.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bus_assert_mux_n                                                      |
// | N-source active-low assert bus mux with keeper and contention count.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module bus_assert_mux_n
    import bus_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NSRC      = 8,
    parameter int LATENCY   = 1,
    parameter int KEEP_LAST = 1
) (
    input  logic            clk,
    input  logic            rst,
    bus_assert_mux_n_if.slave bif
);

    localparam int OWNER_W = owner_w(NSRC);

    logic [NSRC-1:0]    w_req;
    logic               w_any;
    logic               w_multi;
    logic [OWNER_W-1:0] w_idx;
    logic [WIDTH-1:0]   w_sel;
    sel_kind_e          w_kind;

    logic [WIDTH-1:0]   keeper_d,   keeper_q;
    logic [OWNER_W-1:0] owner_d,    owner_q;
    logic [WIDTH-1:0]   bus_d;
    logic               bus_valid_d;
    logic               contention_d, contention_q;
    logic               sticky_d,     sticky_q;
    logic [CNT_W-1:0]   count_d,      count_q;

    assign w_req = ~bif.assert_n;

    bus_assert_prio_enc #(
        .NSRC (NSRC)
    ) u_prio_enc (
        .req   (w_req),
        .any   (w_any),
        .multi (w_multi),
        .idx   (w_idx)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_idx == i[OWNER_W-1:0]) begin
                w_sel = bif.src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_kind = SEL_NONE;
        if (w_multi) begin
            w_kind = SEL_MULTI;
        end else if (w_any) begin
            w_kind = SEL_ONE;
        end
    end

    // Keeper and owner both remember the last real selection across idle cycles.
    always_comb begin
        keeper_d    = keeper_q;
        owner_d     = owner_q;
        bus_valid_d = w_any;
        if (w_kind != SEL_NONE) begin
            keeper_d = w_sel;
            owner_d  = w_idx;
            bus_d    = w_sel;
        end else if (KEEP_LAST != 0) begin
            bus_d    = keeper_q;
        end else begin
            bus_d    = '0;
        end
    end

    // A new contention outranks a simultaneous clear so no event is lost.
    always_comb begin
        contention_d = (w_kind == SEL_MULTI);
        sticky_d     = sticky_q;
        count_d      = count_q;
        if (w_kind == SEL_MULTI) begin
            sticky_d = 1'b1;
            if (bif.clr_err) begin
                count_d = CNT_W'(1);
            end else if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (bif.clr_err) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keeper_q     <= '0;
            owner_q      <= '0;
            contention_q <= 1'b0;
            sticky_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            keeper_q     <= keeper_d;
            owner_q      <= owner_d;
            contention_q <= contention_d;
            sticky_q     <= sticky_d;
            count_q      <= count_d;
        end
    end

    generate
        if (LATENCY != 0) begin : g_registered
            logic [WIDTH-1:0] bus_q;
            logic             bus_valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bus_q       <= '0;
                    bus_valid_q <= 1'b0;
                end else begin
                    bus_q       <= bus_d;
                    bus_valid_q <= bus_valid_d;
                end
            end

            assign bif.bus       = bus_q;
            assign bif.bus_valid = bus_valid_q;
            assign bif.owner     = owner_q;
        end else begin : g_combinational
            // Reset gating keeps the combinational outputs at their reset values.
            assign bif.bus       = rst ? '0 : bus_d;
            assign bif.bus_valid = ~rst & bus_valid_d;
            assign bif.owner     = rst ? '0 : owner_d;
        end
    endgenerate

    assign bif.contention        = contention_q;
    assign bif.contention_sticky = sticky_q;
    assign bif.contention_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_assert_mux_n.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_bus_assert_mux_n                                                   |
// | Table, directed and random checks of three mux configurations.        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_bus_assert_mux_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_assert_mux_n_if #(.WIDTH(8), .NSRC(8)) bif_a ();
    bus_assert_mux_n_if #(.WIDTH(8), .NSRC(8)) bif_b ();
    bus_assert_mux_n_if #(.WIDTH(8), .NSRC(5)) bif_c ();

    bus_assert_mux_n #(.WIDTH(8), .NSRC(8), .LATENCY(1), .KEEP_LAST(1)) u_a (
        .clk (clk), .rst (rst), .bif (bif_a.slave));
    bus_assert_mux_n #(.WIDTH(8), .NSRC(8), .LATENCY(1), .KEEP_LAST(0)) u_b (
        .clk (clk), .rst (rst), .bif (bif_b.slave));
    bus_assert_mux_n #(.WIDTH(8), .NSRC(5), .LATENCY(0), .KEEP_LAST(1)) u_c (
        .clk (clk), .rst (rst), .bif (bif_c.slave));

    typedef struct {
        logic [7:0] keeper;
        logic [2:0] owner_last;
        logic [7:0] bus_r;
        logic       valid_r;
        logic       cont;
        logic       sticky;
        int         count;
    } mst_t;

    typedef struct {
        logic [7:0]  an;
        bit          clr;
        logic [7:0]  bus_a;
        logic [7:0]  bus_b;
        bit          valid;
        logic [2:0]  owner;
        bit          cont;
        bit          sticky;
        logic [15:0] cnt;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    mst_t ma, mb, mc;
    vec_t tbl [12];

    function automatic mst_t m_reset();
        mst_t s;
        s.keeper = '0; s.owner_last = '0; s.bus_r = '0; s.valid_r = 1'b0;
        s.cont = 1'b0; s.sticky = 1'b0; s.count = 0;
        return s;
    endfunction

    function automatic mst_t m_next(mst_t s, logic [63:0] src, logic [7:0] an,
                                    int nsrc, bit keep, bit clr);
        mst_t n;
        int   nact;
        int   win;
        n    = s;
        nact = 0;
        win  = -1;
        for (int i = 0; i < nsrc; i++) begin
            if (!an[i]) begin
                nact++;
                if (win < 0) win = i;
            end
        end
        if (win >= 0) begin
            n.keeper     = src[win*8 +: 8];
            n.owner_last = win[2:0];
            n.bus_r      = src[win*8 +: 8];
            n.valid_r    = 1'b1;
        end else begin
            n.bus_r   = keep ? s.keeper : 8'h00;
            n.valid_r = 1'b0;
        end
        n.cont = (nact >= 2);
        if (nact >= 2) begin
            n.sticky = 1'b1;
            n.count  = clr ? 1 : ((s.count < 65535) ? s.count + 1 : 65535);
        end else if (clr) begin
            n.sticky = 1'b0;
            n.count  = 0;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reg();
        chk("a_bus",    32'(bif_a.bus),               32'(ma.bus_r));
        chk("a_valid",  32'(bif_a.bus_valid),         32'(ma.valid_r));
        chk("a_owner",  32'(bif_a.owner),             32'(ma.owner_last));
        chk("a_cont",   32'(bif_a.contention),        32'(ma.cont));
        chk("a_sticky", 32'(bif_a.contention_sticky), 32'(ma.sticky));
        chk("a_count",  32'(bif_a.contention_count),  ma.count);
        chk("b_bus",    32'(bif_b.bus),               32'(mb.bus_r));
        chk("b_valid",  32'(bif_b.bus_valid),         32'(mb.valid_r));
        chk("b_owner",  32'(bif_b.owner),             32'(mb.owner_last));
        chk("b_cont",   32'(bif_b.contention),        32'(mb.cont));
        chk("b_sticky", 32'(bif_b.contention_sticky), 32'(mb.sticky));
        chk("b_count",  32'(bif_b.contention_count),  mb.count);
        chk("c_cont",   32'(bif_c.contention),        32'(mc.cont));
        chk("c_sticky", 32'(bif_c.contention_sticky), 32'(mc.sticky));
        chk("c_count",  32'(bif_c.contention_count),  mc.count);
    endtask

    task automatic check_c_comb();
        logic [7:0] eb;
        logic       ev;
        logic [2:0] eo;
        int         win;
        win = -1;
        for (int i = 0; i < 5; i++) begin
            if (!bif_c.assert_n[i] && win < 0) win = i;
        end
        if (rst) begin
            eb = '0; ev = 1'b0; eo = '0;
        end else if (win >= 0) begin
            eb = bif_c.src_data[win*8 +: 8]; ev = 1'b1; eo = win[2:0];
        end else begin
            eb = mc.keeper; ev = 1'b0; eo = mc.owner_last;
        end
        chk("c_bus",   32'(bif_c.bus),       32'(eb));
        chk("c_valid", 32'(bif_c.bus_valid), 32'(ev));
        chk("c_owner", 32'(bif_c.owner),     32'(eo));
    endtask

    task automatic reset_models();
        ma = m_reset(); mb = m_reset(); mc = m_reset();
    endtask

    // Inputs change just after an edge; the models follow what the DUTs sampled.
    task automatic cycle(input bit do_chk);
        #1;
        if (do_chk) check_c_comb();
        @(posedge clk);
        if (rst) begin
            reset_models();
        end else begin
            ma = m_next(ma, bif_a.src_data, bif_a.assert_n, 8, 1'b1, bif_a.clr_err);
            mb = m_next(mb, bif_b.src_data, bif_b.assert_n, 8, 1'b0, bif_b.clr_err);
            mc = m_next(mc, {24'h0, bif_c.src_data}, {3'b111, bif_c.assert_n}, 5, 1'b1,
                        bif_c.clr_err);
        end
        #1;
        if (do_chk) check_reg();
    endtask

    task automatic set_ab(input logic [7:0] an, input bit clr);
        bif_a.assert_n = an; bif_b.assert_n = an;
        bif_a.clr_err  = clr; bif_b.clr_err  = clr;
    endtask

    initial begin
        logic [7:0] t8;
        logic [4:0] t5;

        tbl[0]  = '{8'hF7, 0, 8'hA5, 8'hA5, 1, 3'd3, 0, 0, 16'd0};
        tbl[1]  = '{8'hFF, 0, 8'hA5, 8'h00, 0, 3'd3, 0, 0, 16'd0};
        tbl[2]  = '{8'hFF, 0, 8'hA5, 8'h00, 0, 3'd3, 0, 0, 16'd0};
        tbl[3]  = '{8'hE9, 0, 8'h11, 8'h11, 1, 3'd1, 1, 1, 16'd1};
        tbl[4]  = '{8'hE9, 0, 8'h11, 8'h11, 1, 3'd1, 1, 1, 16'd2};
        tbl[5]  = '{8'hE9, 0, 8'h11, 8'h11, 1, 3'd1, 1, 1, 16'd3};
        tbl[6]  = '{8'hFF, 0, 8'h11, 8'h00, 0, 3'd1, 0, 1, 16'd3};
        tbl[7]  = '{8'hFE, 1, 8'h10, 8'h10, 1, 3'd0, 0, 0, 16'd0};
        tbl[8]  = '{8'h7F, 0, 8'h17, 8'h17, 1, 3'd7, 0, 0, 16'd0};
        tbl[9]  = '{8'h3F, 0, 8'h16, 8'h16, 1, 3'd6, 1, 1, 16'd1};
        tbl[10] = '{8'h7F, 1, 8'h17, 8'h17, 1, 3'd7, 0, 0, 16'd0};
        tbl[11] = '{8'hFC, 1, 8'h10, 8'h10, 1, 3'd0, 1, 1, 16'd1};

        reset_models();
        rst = 1'b1;
        bif_a.src_data = 64'h17_16_15_14_A5_12_11_10;
        bif_b.src_data = 64'h17_16_15_14_A5_12_11_10;
        bif_c.src_data = 40'hC4_33_22_11_05;
        bif_c.assert_n = 5'h00;
        bif_c.clr_err  = 1'b0;
        set_ab(8'h00, 1'b0);

        // Reset holds everything at zero even with every source asserting.
        cycle(1);
        cycle(1);
        chk("rst_bus",   32'(bif_a.bus),              32'h0);
        chk("rst_valid", 32'(bif_a.bus_valid),        32'h0);
        chk("rst_owner", 32'(bif_a.owner),            32'h0);
        chk("rst_count", 32'(bif_a.contention_count), 32'h0);
        rst = 1'b0;
        cycle(1);
        chk("post_rst_bus",   32'(bif_a.bus),   32'h10);
        chk("post_rst_owner", 32'(bif_a.owner), 32'h0);

        rst = 1'b1;
        set_ab(8'hFF, 1'b0);
        bif_c.assert_n = 5'h1F;
        cycle(1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            set_ab(tbl[i].an, tbl[i].clr);
            cycle(1);
            chk($sformatf("tbl%0d_a_bus", i),  32'(bif_a.bus),               32'(tbl[i].bus_a));
            chk($sformatf("tbl%0d_b_bus", i),  32'(bif_b.bus),               32'(tbl[i].bus_b));
            chk($sformatf("tbl%0d_valid", i),  32'(bif_a.bus_valid),         32'(tbl[i].valid));
            chk($sformatf("tbl%0d_owner", i),  32'(bif_a.owner),             32'(tbl[i].owner));
            chk($sformatf("tbl%0d_cont", i),   32'(bif_a.contention),        32'(tbl[i].cont));
            chk($sformatf("tbl%0d_sticky", i), 32'(bif_a.contention_sticky), 32'(tbl[i].sticky));
            chk($sformatf("tbl%0d_count", i),  32'(bif_a.contention_count),  32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_b_count", i), 32'(bif_b.contention_count), 32'(tbl[i].cnt));
        end

        // Saturation: far more contention cycles than the counter can hold.
        set_ab(8'h00, 1'b0);
        repeat (65540) cycle(0);
        chk("sat_count_a",  32'(bif_a.contention_count),  32'hFFFF);
        chk("sat_sticky_a", 32'(bif_a.contention_sticky), 32'h1);
        cycle(1);
        chk("sat_hold_b", 32'(bif_b.contention_count), 32'hFFFF);
        set_ab(8'hFF, 1'b1);
        cycle(1);
        chk("clr_count",  32'(bif_a.contention_count),  32'h0);
        chk("clr_sticky", 32'(bif_a.contention_sticky), 32'h0);
        chk("clr_keeper", 32'(bif_a.bus),               32'h10);
        set_ab(8'h00, 1'b1);
        cycle(1);
        chk("clr_cont_count",  32'(bif_a.contention_count),  32'h1);
        chk("clr_cont_sticky", 32'(bif_a.contention_sticky), 32'h1);
        chk("clr_cont_pulse",  32'(bif_a.contention),        32'h1);
        set_ab(8'hFF, 1'b0);
        cycle(1);

        // Combinational instance: same-cycle selection, then a mid-cycle reset pulse.
        bif_c.assert_n = 5'b01111;
        #1;
        chk("c_same_cycle_bus",   32'(bif_c.bus),   32'hC4);
        chk("c_same_cycle_owner", 32'(bif_c.owner), 32'h4);
        cycle(1);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        reset_models();
        bif_c.assert_n = 5'h1F;
        #1;
        chk("c_keeper_after_rst", 32'(bif_c.bus),       32'h0);
        chk("c_valid_after_rst",  32'(bif_c.bus_valid), 32'h0);
        cycle(1);

        for (int k = 0; k < 300; k++) begin
            bif_a.src_data = {$urandom, $urandom};
            bif_b.src_data = {$urandom, $urandom};
            bif_c.src_data = {8'($urandom), $urandom};
            case ($urandom_range(0, 3))
                0:       t8 = 8'hFF;
                1:       t8 = ~(8'h01 << $urandom_range(0, 7));
                default: t8 = 8'($urandom);
            endcase
            bif_a.assert_n = t8;
            bif_b.assert_n = 8'($urandom) | 8'($urandom);
            bif_a.clr_err  = ($urandom_range(0, 7) == 0);
            bif_b.clr_err  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       t5 = 5'h1F;
                1:       t5 = ~(5'h01 << $urandom_range(0, 4));
                default: t5 = 5'($urandom);
            endcase
            bif_c.assert_n = t5;
            bif_c.clr_err  = ($urandom_range(0, 7) == 0);
            cycle(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
